// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: datapath widths, default
// memory latency and the control bundle carried through the M stage.
package mips_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int DATA_W          = 32;
  localparam int MEM_LATENCY_DEF = 2;

  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic mem_write;
  } mem_ctrl_t;

  // Width of a down-counter that must hold lat-1; never narrower than 1 bit.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: asynchronous read, synchronous write.
module data_mem #(
  parameter  int DEPTH_WORDS = 256,
  parameter  int DATA_W      = 32,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Store port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: EX/MEM register, data memory and a latency counter that
// holds loads/stores in M for MEM_LATENCY cycles while stalling the front end.
module memory_stage
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite_E,
  input  logic                  MemtoReg_E,
  input  logic                  MemWrite_E,
  input  logic [REG_ADDR_W-1:0] WriteReg_E,
  input  logic [DATA_W-1:0]     ALUOut_E,
  input  logic [DATA_W-1:0]     WriteData_E,
  input  logic                  Flush_E,
  output logic                  RegWrite_M,
  output logic                  MemtoReg_M,
  output logic [REG_ADDR_W-1:0] WriteReg_M,
  output logic [DATA_W-1:0]     ALUOut_M,
  output logic [DATA_W-1:0]     ReadData_M,
  output logic                  Stall_M
);

  localparam int                AW       = $clog2(DEPTH_WORDS);
  localparam int                CNT_W    = cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  mem_ctrl_t             ctrl_p0;
  logic [REG_ADDR_W-1:0] write_reg_p0;
  logic [DATA_W-1:0]     alu_out_p0;
  logic [DATA_W-1:0]     write_data_p0;
  logic [CNT_W-1:0]      cnt;

  logic                  idle;
  logic                  mem_op_e;
  logic                  mem_we;

  // cnt==0 is both "ready to accept" and "commit cycle of the held instruction".
  assign idle     = (cnt == '0);
  assign mem_op_e = (MemtoReg_E | MemWrite_E) & ~Flush_E;
  assign mem_we   = ctrl_p0.mem_write & idle;

  // ---- E -> M boundary: capture when idle, hold and count down while waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_p0       <= '0;
      write_reg_p0  <= '0;
      alu_out_p0    <= '0;
      write_data_p0 <= '0;
      cnt           <= '0;
    end else if (idle) begin
      ctrl_p0       <= Flush_E ? mem_ctrl_t'('0)
                               : mem_ctrl_t'{RegWrite_E, MemtoReg_E, MemWrite_E};
      write_reg_p0  <= WriteReg_E;
      alu_out_p0    <= ALUOut_E;
      write_data_p0 <= WriteData_E;
      cnt           <= mem_op_e ? CNT_LOAD : '0;
    end else begin
      cnt           <= cnt - CNT_W'(1);
    end
  end

  // Store lands only at the edge ending the commit cycle, so an aborted
  // access (reset while waiting) never touches memory.
  data_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_W      (DATA_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (alu_out_p0[AW+1:2]),
    .wdata (write_data_p0),
    .rdata (ReadData_M)
  );

  // ---- M -> WB boundary: bubble the write-back controls while waiting
  assign Stall_M    = ~idle;
  assign RegWrite_M = ctrl_p0.reg_write & idle;
  assign MemtoReg_M = ctrl_p0.memto_reg & idle;
  assign WriteReg_M = write_reg_p0;
  assign ALUOut_M   = alu_out_p0;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: three instances (latency 1, 2, 3) share the
// same E-side stimulus; each step checks hand-computed outputs.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_E, MemtoReg_E, MemWrite_E, Flush_E;
  logic [4:0]  WriteReg_E;
  logic [31:0] ALUOut_E, WriteData_E;

  logic        rw1, mtr1, st1;
  logic [4:0]  wr1;
  logic [31:0] alu1, rd1;
  logic        rw2, mtr2, st2;
  logic [4:0]  wr2;
  logic [31:0] alu2, rd2;
  logic        rw3, mtr3, st3;
  logic [4:0]  wr3;
  logic [31:0] alu3, rd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
    .MemWrite_E(MemWrite_E), .WriteReg_E(WriteReg_E), .ALUOut_E(ALUOut_E),
    .WriteData_E(WriteData_E), .Flush_E(Flush_E), .RegWrite_M(rw1),
    .MemtoReg_M(mtr1), .WriteReg_M(wr1), .ALUOut_M(alu1), .ReadData_M(rd1),
    .Stall_M(st1));

  memory_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
    .MemWrite_E(MemWrite_E), .WriteReg_E(WriteReg_E), .ALUOut_E(ALUOut_E),
    .WriteData_E(WriteData_E), .Flush_E(Flush_E), .RegWrite_M(rw2),
    .MemtoReg_M(mtr2), .WriteReg_M(wr2), .ALUOut_M(alu2), .ReadData_M(rd2),
    .Stall_M(st2));

  memory_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
    .MemWrite_E(MemWrite_E), .WriteReg_E(WriteReg_E), .ALUOut_E(ALUOut_E),
    .WriteData_E(WriteData_E), .Flush_E(Flush_E), .RegWrite_M(rw3),
    .MemtoReg_M(mtr3), .WriteReg_M(wr3), .ALUOut_M(alu3), .ReadData_M(rd3),
    .Stall_M(st3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic rw, input logic mtr, input logic mw,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] wd, input logic fl);
    RegWrite_E  = rw;
    MemtoReg_E  = mtr;
    MemWrite_E  = mw;
    WriteReg_E  = wr;
    ALUOut_E    = alu;
    WriteData_E = wd;
    Flush_E     = fl;
  endtask

  task automatic nop();
    set_e(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    // Reset with random E inputs
    rst = 1'b1;
    set_e(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
          $urandom, $urandom, 1'($urandom));
    tick();
    set_e(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
          $urandom, $urandom, 1'($urandom));
    tick();
    check("rst_rw3",    32'(rw3),  32'd0);
    check("rst_mtr3",   32'(mtr3), 32'd0);
    check("rst_wr3",    32'(wr3),  32'd0);
    check("rst_alu3",   alu3,      32'd0);
    check("rst_stall3", 32'(st3),  32'd0);
    check("rst_stall2", 32'(st2),  32'd0);
    check("rst_rw1",    32'(rw1),  32'd0);

    // ALU op: visible next cycle, no stall
    rst = 1'b0;
    set_e(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0, 1'b0);
    tick();
    check("alu_rw2",    32'(rw2),  32'd1);
    check("alu_wr2",    32'(wr2),  32'd5);
    check("alu_out2",   alu2,      32'h1234);
    check("alu_stall2", 32'(st2),  32'd0);
    check("alu_mtr2",   32'(mtr2), 32'd0);
    check("alu_rw3",    32'(rw3),  32'd1);
    check("alu_stall3", 32'(st3),  32'd0);

    // Store 0xDEADBEEF to 0x40
    set_e(1'b0, 1'b0, 1'b1, 5'd0, 32'h40, 32'hDEADBEEF, 1'b0);
    tick();
    check("st_w1_stall3", 32'(st3), 32'd1);
    check("st_w1_rw3",    32'(rw3), 32'd0);
    check("st_w1_stall2", 32'(st2), 32'd1);
    check("st_stall1",    32'(st1), 32'd0);
    nop();
    tick();
    check("st_w2_stall3", 32'(st3), 32'd1);
    check("st_w2_rw3",    32'(rw3), 32'd0);
    check("st_c_stall2",  32'(st2), 32'd0);
    tick();
    check("st_c_stall3",  32'(st3), 32'd0);

    // Load from 0x40 into r8, back-to-back with the store's commit
    set_e(1'b1, 1'b1, 1'b0, 5'd8, 32'h40, 32'h0, 1'b0);
    tick();
    check("ld_w1_stall3", 32'(st3),  32'd1);
    check("ld_w1_rw3",    32'(rw3),  32'd0);
    check("ld_w1_mtr3",   32'(mtr3), 32'd0);
    nop();
    tick();
    check("ld_w2_stall3", 32'(st3),  32'd1);
    check("ld_c_mtr2",    32'(mtr2), 32'd1);
    check("ld_c_rd2",     rd2,       32'hDEADBEEF);
    tick();
    check("ld_c_stall3",  32'(st3),  32'd0);
    check("ld_c_rw3",     32'(rw3),  32'd1);
    check("ld_c_mtr3",    32'(mtr3), 32'd1);
    check("ld_c_wr3",     32'(wr3),  32'd8);
    check("ld_c_rd3",     rd3,       32'hDEADBEEF);

    // Address wrap: store 0x55 to 0x400, load from 0x000 into r9
    set_e(1'b0, 1'b0, 1'b1, 5'd0, 32'h400, 32'h55, 1'b0);
    tick();
    nop();
    tick();
    tick();
    check("wrap_st_c_stall3", 32'(st3), 32'd0);
    set_e(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0, 1'b0);
    tick();
    nop();
    tick();
    tick();
    check("wrap_ld_stall3", 32'(st3), 32'd0);
    check("wrap_ld_wr3",    32'(wr3), 32'd9);
    check("wrap_ld_rd3",    rd3,      32'h55);

    // Flush while idle: load becomes a bubble, no stall
    set_e(1'b1, 1'b1, 1'b0, 5'd10, 32'h40, 32'h0, 1'b1);
    tick();
    check("flush_idle_stall3", 32'(st3),  32'd0);
    check("flush_idle_rw3",    32'(rw3),  32'd0);
    check("flush_idle_mtr3",   32'(mtr3), 32'd0);

    // Flush while stalled is ignored: pending load r11 from 0x40 commits
    set_e(1'b1, 1'b1, 1'b0, 5'd11, 32'h40, 32'h0, 1'b0);
    tick();
    check("flush_w1_stall3", 32'(st3), 32'd1);
    set_e(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
    tick();
    check("flush_w2_stall3", 32'(st3), 32'd1);
    tick();
    check("flush_c_stall3", 32'(st3),  32'd0);
    check("flush_c_rw3",    32'(rw3),  32'd1);
    check("flush_c_mtr3",   32'(mtr3), 32'd1);
    check("flush_c_wr3",    32'(wr3),  32'd11);
    check("flush_c_rd3",    rd3,       32'hDEADBEEF);

    // Reset in first WAIT cycle of a store to 0x80 (which holds 0x0)
    set_e(1'b0, 1'b0, 1'b1, 5'd0, 32'h80, 32'h0, 1'b0);
    tick();
    nop();
    tick();
    tick();
    set_e(1'b0, 1'b0, 1'b1, 5'd0, 32'h80, 32'hCAFEF00D, 1'b0);
    tick();
    check("abort_w1_stall3", 32'(st3), 32'd1);
    rst = 1'b1;
    set_e(1'b1, 1'b1, 1'b0, 5'd3, 32'h44, 32'h0, 1'b1);
    tick();
    check("abort_stall3", 32'(st3), 32'd0);
    check("abort_rw3",    32'(rw3), 32'd0);
    check("abort_alu3",   alu3,     32'd0);
    rst = 1'b0;
    set_e(1'b1, 1'b1, 1'b0, 5'd12, 32'h80, 32'h0, 1'b0);
    tick();
    nop();
    tick();
    tick();
    check("abort_ld_stall3", 32'(st3), 32'd0);
    check("abort_ld_wr3",    32'(wr3), 32'd12);
    check("abort_ld_rd3",    rd3,      32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the pipelined MIPS core: EX/MEM pipeline register, data memory, and a latency counter that stretches loads and stores over a configurable number of cycles. It sits between the execute stage and the write-back pipeline register, and drives that register's `_M` inputs directly. While an access is in flight it raises a stall to the hazard unit and presents a bubble downstream.

## Interface
- `DEPTH_WORDS`, 256: data memory depth in 32-bit words; power of two.
- `MEM_LATENCY`, 2: cycles a load/store occupies the M stage, ≥1; 1 = classic single-cycle access.

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `RegWrite_E, MemtoReg_E, MemWrite_E`  in  1 each  control from execute
- `WriteReg_E`  in  5  destination register
- `ALUOut_E`  in  32  ALU result / byte address
- `WriteData_E`  in  32  store data
- `Flush_E`  in  1  load a bubble instead of the E-side instruction
- `RegWrite_M, MemtoReg_M`  out  1 each  control to write-back register
- `WriteReg_M`  out  5  destination register
- `ALUOut_M, ReadData_M`  out  32 each  ALU result, load data
- `Stall_M`  out  1  access in flight; hazard unit freezes F/D/E

## Operation
- Internal M register holds the E-side fields: RegWrite, MemtoReg, MemWrite, WriteReg, ALUOut, WriteData.
- `cnt` is a down-counter, width `$clog2(MEM_LATENCY)`, min 1 bit.
- FSM is implicit in `cnt`:
  - IDLE when `cnt==0`.
  - WAIT when `cnt!=0`.
  - `Stall_M = (cnt != 0)`.
- Rising edge with `Stall_M==0`:
  - M register loads E fields; `Flush_E=1` loads all control bits 0 instead.
  - If the loaded instruction is a memory op (`MemtoReg_E|MemWrite_E`, not flushed), `cnt <= MEM_LATENCY-1`; else `cnt <= 0`.
- Rising edge with `Stall_M==1`:
  - M register holds.
  - `cnt <= cnt-1`.
  - `Flush_E` is ignored.
- Commit cycle: any cycle with `cnt==0`.
  - `RegWrite_M`/`MemtoReg_M` = registered values.
  - Store writes memory at the end of the commit cycle only, which makes a reset during WAIT abort with no memory side effect.
- Outputs during WAIT:
  - `RegWrite_M=0`, `MemtoReg_M=0` (bubble).
  - `WriteReg_M`, `ALUOut_M`, `ReadData_M` show register/memory values but are don't-care to WB.
- Addressing:
  - word index = `ALUOut[$clog2(DEPTH_WORDS)+1:2]`.
  - bits [1:0] ignored; higher bits ignored (address wraps modulo depth).
- `ReadData_M` = asynchronous read of `mem[index]` from the current M register address.
- Read-after-store: a store commits at the edge ending its commit cycle, so a following load reads the new value.
- Reset:
  - clears the M register (all fields 0) and `cnt`.
  - outputs go to 0, including `Stall_M=0`.
  - memory contents are not reset.

## Timing
- Non-memory instruction at E in cycle n: on M outputs in cycle n+1, with `Stall_M=0`.
- Load/store at E in cycle n:
  - `Stall_M=1` in cycles n+1 … n+MEM_LATENCY-1.
  - commit in cycle n+MEM_LATENCY; WB register captures at the end of that cycle.
- `MEM_LATENCY=1`: `Stall_M` is never asserted; pure one-cycle register.
- Back-to-back memory ops: the second is captured on the edge ending the first one's commit cycle, giving MEM_LATENCY cycles each with no gap.
- `rst` asserted during WAIT: next cycle is IDLE with a bubble; the in-flight store is dropped.
- `rst` and `Flush_E` together: `rst` wins.

## Structure
- Shared package `mips_pkg`:
  - `REG_ADDR_W=5`, `DATA_W=32`.
  - default `MEM_LATENCY`.
  - packed struct `mem_ctrl_t` {RegWrite, MemtoReg, MemWrite}.
- Sub-module `data_mem`: `DEPTH_WORDS`×32 array, async read, sync write with write-enable. `memory_stage` instantiates it once.

## Test plan
- Reset: `rst=1` for 2 cycles with random E inputs -> all outputs 0, `Stall_M=0`.
- ALU op with `MEM_LATENCY=2` (`RegWrite_E=1`, `WriteReg_E=5`, `ALUOut_E=0x1234`) -> next cycle `RegWrite_M=1`, `WriteReg_M=5`, `ALUOut_M=0x1234`, `Stall_M=0`.
- With `MEM_LATENCY=3`:
  - store 0xDEADBEEF to address 0x40 -> `Stall_M` high for 2 cycles with `RegWrite_M=0`.
  - then load from 0x40 into r8 -> `Stall_M` high for 2 cycles, then commit with `ReadData_M=0xDEADBEEF`, `MemtoReg_M=1`, `WriteReg_M=8`.
- Address wrap, `DEPTH_WORDS=256`: store 0x55 to 0x400, load from 0x000 -> `ReadData_M=0x55`.
- `Flush_E=1` with a load at E while IDLE -> bubble, no stall. `Flush_E=1` while `Stall_M=1` -> ignored, the pending load still commits.
- Assert `rst` in the first WAIT cycle of a store to 0x80 holding 0x0 -> IDLE next cycle; a later load from 0x80 returns 0x0.
